// File: rtl/niosii_tutorial_cpu_oci_dct_packer.sv
// OCI DCT trace packer: packs 2-bit atoms into 30-bit frames and hands them
// to the readout path over valid/ready without ever stalling the CPU.
module niosii_tutorial_cpu_oci_dct_packer #(
    parameter int unsigned ATOM_W = 2,
    parameter int unsigned ATOMS  = 15,
    localparam int unsigned FRAME_W = ATOM_W * ATOMS,
    localparam int unsigned CNT_W   = $clog2(ATOMS + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trace_enable,
    input  logic               atom_valid,
    input  logic [ATOM_W-1:0]  atom_data,
    input  logic               flush_req,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [FRAME_W-1:0] frame_data,
    output logic [CNT_W-1:0]   frame_count,
    output logic [FRAME_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               overflow,
    input  logic               overflow_clr,
    output logic               flush_done
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(ATOMS);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_BLOCKED,
        ST_FLUSH_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 oval_q, oval_d;
    logic [FRAME_W-1:0]   odata_q, odata_d;
    logic [CNT_W-1:0]     ocnt_q, ocnt_d;

    logic                 atom_in;
    logic                 out_free;
    logic                 move;
    logic [FRAME_W-1:0]   nbuf;
    logic [CNT_W-1:0]     ncnt;

    assign atom_in  = atom_valid & trace_enable;
    assign out_free = ~oval_q | frame_ready;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q & ~overflow_clr;
        move    = 1'b0;
        nbuf    = buf_q;
        ncnt    = cnt_q + CNT_W'(atom_in);

        for (int unsigned k = 0; k < ATOMS; k++) begin
            if (atom_in && cnt_q == CNT_W'(k)) begin
                nbuf[k*ATOM_W +: ATOM_W] = atom_data;
            end
        end

        unique case (state_q)
            ST_EMPTY, ST_FILLING: begin
                // A completed or flushed frame is staged here and handed over on the following edge.
                buf_d = nbuf;
                cnt_d = ncnt;
                if (ncnt == FULL) begin
                    state_d = ST_BLOCKED;
                    pend_d  = flush_req;
                end else if (flush_req) begin
                    if (ncnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FLUSH_WAIT;
                    end
                end else begin
                    state_d = (ncnt == '0) ? ST_EMPTY : ST_FILLING;
                end
            end
            ST_BLOCKED: begin
                if (out_free) begin
                    move   = 1'b1;
                    done_d = pend_q | flush_req;
                    pend_d = 1'b0;
                    buf_d  = '0;
                    if (atom_in) begin
                        buf_d[ATOM_W-1:0] = atom_data;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_FILLING;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_EMPTY;
                    end
                end else begin
                    if (atom_in)   ovf_d  = 1'b1;
                    if (flush_req) pend_d = 1'b1;
                end
            end
            ST_FLUSH_WAIT: begin
                if (atom_in) ovf_d = 1'b1;
                if (out_free) begin
                    move    = 1'b1;
                    done_d  = 1'b1;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        oval_d  = oval_q & ~frame_ready;
        odata_d = odata_q;
        ocnt_d  = ocnt_q;
        if (move) begin
            oval_d  = 1'b1;
            odata_d = buf_q;
            ocnt_d  = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            buf_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            oval_q  <= 1'b0;
            odata_q <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            oval_q  <= oval_d;
            odata_q <= odata_d;
            ocnt_q  <= ocnt_d;
        end
    end

    assign frame_valid = oval_q;
    assign frame_data  = odata_q;
    assign frame_count = ocnt_q;
    assign dct_buffer  = buf_q;
    assign dct_count   = cnt_q;
    assign overflow    = ovf_q;
    assign flush_done  = done_q;

endmodule

// File: tb/tb_niosii_tutorial_cpu_oci_dct_packer.sv
// Bench for the DCT packer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_niosii_tutorial_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trace_enable = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = '0;
    logic        flush_req = 1'b0;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic        flush_done;

    int checks = 0;
    int errors = 0;

    niosii_tutorial_cpu_oci_dct_packer #(.ATOM_W(2), .ATOMS(15)) dut (
        .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable),
        .atom_valid(atom_valid), .atom_data(atom_data), .flush_req(flush_req),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_data(frame_data), .frame_count(frame_count),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .overflow(overflow), .overflow_clr(overflow_clr), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: atoms in a queue, frames as packed sums.
    int          fillq[$];
    bit          m_full_wait, m_flush_wait, m_pend, m_ov, m_done, m_oval;
    logic [29:0] m_odata;
    int          m_ocnt;

    function automatic logic [29:0] pack(input int q[$]);
        logic [29:0] v = '0;
        foreach (q[i]) v = v | (30'(q[i]) << (2 * i));
        return v;
    endfunction

    task automatic emit();
        m_oval  = 1'b1;
        m_odata = pack(fillq);
        m_ocnt  = fillq.size();
        fillq.delete();
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fillq.delete();
            m_full_wait = 0; m_flush_wait = 0; m_pend = 0;
            m_ov = 0; m_done = 0; m_oval = 0; m_odata = '0; m_ocnt = 0;
        end else begin
            bit take, free, nd;
            take = atom_valid && trace_enable;
            free = !m_oval || frame_ready;
            nd   = 0;
            if (overflow_clr) m_ov = 0;
            if (frame_ready) m_oval = 0;
            if (m_full_wait) begin
                if (free) begin
                    emit();
                    nd = m_pend || flush_req;
                    m_pend = 0;
                    m_full_wait = 0;
                    if (take) fillq.push_back(int'(atom_data));
                end else begin
                    if (take) m_ov = 1;
                    if (flush_req) m_pend = 1;
                end
            end else if (m_flush_wait) begin
                if (take) m_ov = 1;
                if (free) begin
                    emit();
                    nd = 1;
                    m_flush_wait = 0;
                end
            end else begin
                if (take) fillq.push_back(int'(atom_data));
                if (fillq.size() == 15) begin
                    m_full_wait = 1;
                    m_pend = flush_req;
                end else if (flush_req) begin
                    if (fillq.size() == 0) nd = 1;
                    else m_flush_wait = 1;
                end
            end
            m_done = nd;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("frame_valid", 32'(frame_valid), 32'(m_oval));
            if (m_oval) begin
                chk("frame_data", 32'(frame_data), 32'(m_odata));
                chk("frame_count", 32'(frame_count), 32'(m_ocnt));
            end
            chk("dct_count", 32'(dct_count), 32'(fillq.size()));
            chk("dct_buffer", 32'(dct_buffer), 32'(pack(fillq)));
            chk("overflow", 32'(overflow), 32'(m_ov));
            chk("flush_done", 32'(flush_done), 32'(m_done));
        end
    end

    task automatic step(input bit av, input logic [1:0] ad, input bit fl);
        atom_valid = av;
        atom_data  = ad;
        flush_req  = fl;
        @(negedge clk);
        atom_valid   = 1'b0;
        flush_req    = 1'b0;
        overflow_clr = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_dct_count", 32'(dct_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset_n = 1'b1;
        trace_enable = 1'b1;
        frame_ready = 1'b1;
        step(0, 2'b00, 0);

        // T1: full frame of 2'b01 atoms
        for (int i = 0; i < 15; i++) step(1, 2'b01, 0);
        chk("t1_not_yet_valid", 32'(frame_valid), 0);
        chk("t1_count_full", 32'(dct_count), 15);
        step(0, 2'b00, 0);
        chk("t1_valid", 32'(frame_valid), 1);
        chk("t1_data", 32'(frame_data), 32'h15555555);
        chk("t1_count", 32'(frame_count), 15);
        chk("t1_dct_count", 32'(dct_count), 0);
        step(0, 2'b00, 0);

        // T2: partial flush, then flush on empty
        step(1, 2'b11, 0);
        step(1, 2'b10, 0);
        step(1, 2'b01, 0);
        step(0, 2'b00, 1);
        step(0, 2'b00, 0);
        chk("t2_valid", 32'(frame_valid), 1);
        chk("t2_data", 32'(frame_data), 32'h1B);
        chk("t2_count", 32'(frame_count), 3);
        chk("t2_done", 32'(flush_done), 1);
        step(0, 2'b00, 1);
        chk("t2_empty_done", 32'(flush_done), 1);
        chk("t2_empty_novalid", 32'(frame_valid), 0);
        step(0, 2'b00, 0);

        // T4: atom and flush in the same cycle at count 4
        step(1, 2'b00, 0);
        step(1, 2'b01, 0);
        step(1, 2'b10, 0);
        step(1, 2'b11, 0);
        step(1, 2'b10, 1);
        step(0, 2'b00, 0);
        chk("t4_count", 32'(frame_count), 5);
        chk("t4_data", 32'(frame_data), 32'h2E4);
        step(0, 2'b00, 0);
        step(0, 2'b00, 0);

        // T3: consumer stalled, 31 atoms
        frame_ready = 1'b0;
        for (int i = 0; i < 31; i++) step(1, 2'(i), 0);
        chk("t3_blocked_count", 32'(dct_count), 15);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_held", 32'(frame_valid), 1);
        frame_ready = 1'b1;
        step(0, 2'b00, 0);
        chk("t3_frame2_valid", 32'(frame_valid), 1);
        chk("t3_frame2_count", 32'(frame_count), 15);
        step(0, 2'b00, 0);
        chk("t3_drained", 32'(frame_valid), 0);

        // T6: clear overflow, disabled trace, then clear vs set collision
        overflow_clr = 1'b1;
        step(0, 2'b00, 0);
        chk("t6_cleared", 32'(overflow), 0);
        trace_enable = 1'b0;
        for (int i = 0; i < 20; i++) step(1, 2'b11, 0);
        chk("t6_dis_count", 32'(dct_count), 0);
        chk("t6_dis_overflow", 32'(overflow), 0);
        trace_enable = 1'b1;
        frame_ready = 1'b0;
        for (int i = 0; i < 30; i++) step(1, 2'b10, 0);
        overflow_clr = 1'b1;
        step(1, 2'b01, 0);
        chk("t6_set_wins", 32'(overflow), 1);
        frame_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 2'b00, 0);

        // T5: asynchronous reset mid-frame with an output frame pending
        frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) step(1, 2'b11, 0);
        chk("t5_pre_count", 32'(dct_count), 7);
        chk("t5_pre_valid", 32'(frame_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(frame_valid), 0);
        chk("t5_rst_data", 32'(frame_data), 0);
        chk("t5_rst_fcount", 32'(frame_count), 0);
        chk("t5_rst_buffer", 32'(dct_buffer), 0);
        chk("t5_rst_count", 32'(dct_count), 0);
        chk("t5_rst_overflow", 32'(overflow), 0);
        chk("t5_rst_done", 32'(flush_done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        frame_ready = 1'b1;
        step(0, 2'b00, 0);
        for (int i = 0; i < 15; i++) step(1, 2'b10, 0);
        step(0, 2'b00, 0);
        chk("t5_after_valid", 32'(frame_valid), 1);
        chk("t5_after_data", 32'(frame_data), 32'h2AAAAAAA);
        chk("t5_after_count", 32'(frame_count), 15);
        step(0, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
